// File: rtl/bus_rx_pkg.sv
// Shared types and constants for the bus receive port.
// Both the bus initiator side and the receive block import these.
package bus_rx_pkg;
  localparam int NPORTS = 8;
  localparam int PORT_W = 3;
  localparam int DATA_W = 32;

  typedef logic [PORT_W-1:0] port_t;
  typedef logic [DATA_W-1:0] data_t;

  // Add one, but stick at all-ones instead of wrapping to zero.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/bus_port_rx_if.sv
// Bus initiator -> receive block signal group.
// There is no ready signal: the initiator never stalls.
interface bus_port_rx_if;
  import bus_rx_pkg::*;

  data_t data;
  port_t port;
  logic  valid;

  modport master (output data, port, valid);
  modport slave  (input  data, port, valid);
endinterface

// File: rtl/bus_port_rx_port_fifo.sv
// Single-clock FIFO for one destination port.
// Pointers wrap naturally because DEPTH is a power of two.
// The occupancy counter is one bit wider than the pointers,
// so it can tell full apart from empty.
module port_fifo
  import bus_rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  data_t din,
  output data_t dout,
  output logic  empty,
  output logic  full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  data_t           mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            push_ok;
  logic            pop_ok;

  // Guard against caller mistakes: never overrun or underrun the array.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage is left unreset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // The head word is read straight from the array.
  // The top level registers it when the pop happens.
  assign dout  = mem[rd_ptr_reg];
  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));
endmodule

// File: rtl/bus_port_rx.sv
// Bus receive block.
// Incoming words are demultiplexed into eight per-port FIFOs.
// One port at a time is popped, and the result appears one cycle later.
// All flags come from registered FIFO state. A write and a pop on the same
// port in the same cycle are therefore judged against the pre-edge
// occupancy of that port.
module bus_port_rx
  import bus_rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  bus_port_rx_if.slave       bus,
  input  port_t              rd_port,
  input  logic               rd_en,
  output data_t              rd_data,
  output logic               rd_valid,
  output logic [NPORTS-1:0]  empty,
  output logic [NPORTS-1:0]  full,
  output logic [15:0]        drop_cnt,
  output logic [31:0]        rx_cnt
);
  logic [NPORTS-1:0] push;
  logic [NPORTS-1:0] pop;
  data_t             head [NPORTS];

  data_t             rd_data_reg,  rd_data_next;
  logic              rd_valid_reg, rd_valid_next;
  logic [15:0]       drop_cnt_reg, drop_cnt_next;
  logic [31:0]       rx_cnt_reg,   rx_cnt_next;

  logic              accept;
  logic              drop;
  logic              pop_hit;

  // Write demux: each FIFO sees only words addressed to it.
  // Read select: only the chosen port is popped.
  generate
    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
      assign push[gi] = bus.valid && (bus.port == port_t'(gi)) && !full[gi];
      assign pop[gi]  = rd_en && (rd_port == port_t'(gi)) && !empty[gi];

      port_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push[gi]),
        .pop   (pop[gi]),
        .din   (bus.data),
        .dout  (head[gi]),
        .empty (empty[gi]),
        .full  (full[gi])
      );
    end
  endgenerate

  assign accept  = bus.valid && !full[bus.port];
  assign drop    = bus.valid &&  full[bus.port];
  assign pop_hit = rd_en && !empty[rd_port];

  // Next-state for the read result and the two counters.
  // rd_data holds its value when no pop succeeds.
  always_comb begin
    rd_valid_next = pop_hit;
    rd_data_next  = pop_hit ? head[rd_port] : rd_data_reg;
    rx_cnt_next   = accept ? rx_cnt_reg + 32'd1 : rx_cnt_reg;
    drop_cnt_next = drop ? sat_inc16(drop_cnt_reg) : drop_cnt_reg;
  end

  // Read result register and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
      drop_cnt_reg <= '0;
      rx_cnt_reg   <= '0;
    end else begin
      rd_data_reg  <= rd_data_next;
      rd_valid_reg <= rd_valid_next;
      drop_cnt_reg <= drop_cnt_next;
      rx_cnt_reg   <= rx_cnt_next;
    end
  end

  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;
  assign drop_cnt = drop_cnt_reg;
  assign rx_cnt   = rx_cnt_reg;
endmodule

// File: doc/bus_port_rx.md
BUS_PORT_RX -- requirements
Module: bus_port_rx

Interface
REQ-001 Parameter DEPTH, default 4, meaning per-port FIFO depth in words; must be a power of two, minimum 2.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 data  input  32  bus data word, driven by the bus initiator.
REQ-005 port  input  3  destination port number, 0..7.
REQ-006 valid  input  1  data/port qualify this cycle.
REQ-007 rd_port  input  3  port selected for readout.
REQ-008 rd_en  input  1  pop request for rd_port.
REQ-009 rd_data  output  32  popped word, registered.
REQ-010 rd_valid  output  1  rd_data valid, one-cycle pulse.
REQ-011 empty  output  8  per-port empty flags, bit n = port n.
REQ-012 full  output  8  per-port full flags, bit n = port n.
REQ-013 drop_cnt  output  16  count of words dropped because their port was full.
REQ-014 rx_cnt  output  32  count of words accepted.

Function
REQ-015 The block SHALL hold eight independent FIFOs, one per port value, each DEPTH words of 32 bits.
REQ-016 valid=1 with full[port]=0 at a posedge SHALL write data into FIFO[port] and increment rx_cnt.
- The word is visible as non-empty in the next cycle.
REQ-017 valid=1 with full[port]=1 SHALL discard the word and increment drop_cnt. No backpressure exists; the initiator never stalls.
REQ-018 drop_cnt SHALL saturate at 16'hFFFF. rx_cnt SHALL wrap modulo 2^32.
REQ-019 valid=0 SHALL ignore data and port entirely.
REQ-020 rd_en=1 with empty[rd_port]=0 SHALL pop FIFO[rd_port].
- rd_data is presented with rd_valid=1 on the following cycle (latency 1).
REQ-021 rd_en=1 with empty[rd_port]=1 SHALL have no effect: rd_valid=0 next cycle, rd_data holds its previous value.
REQ-022 rd_valid SHALL be 0 in every cycle not immediately following a successful pop.
REQ-023 Flag evaluation SHALL use pre-edge state.
- Write to a full port while the same port is popped in the same cycle: the write is dropped, the pop succeeds.
- Pop of an empty port while the same port is written in the same cycle: the pop fails, the write is stored.
REQ-024 Write and pop on different ports in the same cycle SHALL both complete.
REQ-025 Each FIFO SHALL preserve arrival order. Pointers wrap modulo DEPTH; an occupancy counter of width log2(DEPTH)+1 distinguishes full from empty.
REQ-026 empty and full SHALL be registered-state derived, with no combinational path from valid, port, rd_en or rd_port.

Reset
REQ-027 rst=1 SHALL asynchronously clear all pointers and occupancy counters, giving the following output values:
- empty=8'hFF
- full=8'h00
- rd_valid=0
- rd_data=0
- drop_cnt=0
- rx_cnt=0
REQ-028 Reset asserted mid-operation SHALL discard all stored words. No pop result SHALL appear after reset release.
REQ-029 FIFO storage arrays need not be reset.

Structure
REQ-030 Shared package bus_rx_pkg SHALL define the following, for reuse by the bench and the bus initiator side:
- NPORTS=8
- port_t (3-bit)
- data_t (32-bit)
REQ-031 One sub-module, port_fifo (single-clock, DEPTH-parameterised, push/pop/empty/full), SHALL be instantiated NPORTS times via generate.
REQ-032 Top-level logic SHALL be limited to the following:
- write demux
- read mux
- rd_data/rd_valid register
- the two counters

Verification
REQ-033 Reset: pulse rst mid-test with port 3 holding 2 words -> empty=8'hFF, rd_en to port 3 next cycle gives rd_valid=0.
REQ-034 Ordering: write 32'hA0, A1, A2 to port 5, then pop port 5 three times -> rd_data A0, A1, A2 on the cycles after each pop; empty[5]=1 afterwards.
REQ-035 Overflow: 6 back-to-back writes to port 2 with DEPTH=4 -> full[2]=1 after 4th, drop_cnt=2, rx_cnt=4, pops return first 4 words.
REQ-036 Simultaneous: port 7 full, write 32'hDEAD to port 7 plus pop port 7 in the same cycle -> drop_cnt +1, oldest word popped, occupancy 3.
REQ-037 Empty pop with concurrent write: port 0 empty, write 32'h55 plus pop port 0 -> rd_valid=0; next pop returns 32'h55.
REQ-038 Random: constrained-random port/data/valid for 10k cycles against a scoreboard model, with full coverage of all 8 ports × {accept, drop} × {pop hit, pop miss}.
